// File: rtl/quint_pkg.sv
// Shared constants and types for the quint_sched round-robin x5 scheduler.
package quint_pkg;
  localparam int DATA_W  = 6;
  localparam int RES_W   = 12;
  localparam int QUINT_K = 5;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, with wrap.
module rr_pick
  import quint_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = IDW'((32'(ptr) + i) % NREQ);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/quint_sched.sv
// Round-robin scheduler sharing one signed x5 datapath among NREQ requesters.
// Optional 8-bit output clamp enabled by defining QUINT_SAT8_EN.
module quint_sched
  import quint_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [DATA_W*NREQ-1:0] req_a,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [RES_W-1:0]       rsp_y,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_sat,
  output logic [15:0]            ops_cnt
);

  state_t state, state_next;

  logic [IDW-1:0]           rr_ptr;
  logic [IDW-1:0]           pick_idx;
  logic [NREQ-1:0]          pick_grant;
  logic                     pick_any;
  logic                     slot_free;
  logic                     grant_en;
  logic signed [DATA_W-1:0] a_sel;
  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  prod;
  logic [RES_W-1:0]         y_next;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A held result leaving this cycle frees the slot for a same-cycle grant.
  assign slot_free = (state == EMPTY) | rsp_ready;
  assign grant_en  = slot_free & pick_any & ~rst;
  assign req_ready = grant_en ? pick_grant : '0;
  assign rsp_valid = (state == FULL);

  always_comb begin
    a_sel = req_a[DATA_W*int'(pick_idx) +: DATA_W];
    a_ext = RES_W'(a_sel);
    prod  = a_ext * RES_W'(QUINT_K);
  end

`ifdef QUINT_SAT8_EN
  localparam logic signed [RES_W-1:0] SAT_HI = RES_W'(SAT_MAX);
  localparam logic signed [RES_W-1:0] SAT_LO = RES_W'(SAT_MIN);

  logic sat_next;
  logic sat_q;

  always_comb begin
    y_next   = prod;
    sat_next = 1'b0;
    if (prod > SAT_HI) begin
      y_next   = SAT_HI;
      sat_next = 1'b1;
    end else if (prod < SAT_LO) begin
      y_next   = SAT_LO;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (grant_en) begin
      sat_q <= sat_next;
    end
  end

  assign rsp_sat = sat_q;
`else
  assign y_next  = prod;
  assign rsp_sat = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (grant_en) begin
      state_next = FULL;
    end else if (state == FULL && rsp_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_y   <= '0;
      rsp_id  <= '0;
      rr_ptr  <= '0;
      ops_cnt <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        ops_cnt <= ops_cnt + 16'd1;
      end
      if (grant_en) begin
        rsp_y  <= y_next;
        rsp_id <= pick_idx;
        rr_ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

endmodule
